// File: rtl/mdu_sequencer.sv
// -----------------------------------------------------------------------------
// mdu_sequencer
//   Multi-cycle MULT / MULTU / DIV / DIVU engine. It has no adder of its own.
//   Every add, subtract and negate goes through the core's shared 32-bit ALU.
//   The sequencer owns that ALU (alu_grant=1) for the whole time it is busy.
//
//   Algorithm:
//     - Signed operands are first reduced to magnitudes (PRE_A / PRE_B).
//     - A 32-step shift-add multiply or restoring divide runs over {hi,lo}.
//     - Signed results are corrected afterwards (POST_LO / POST_HI).
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   start, md_op        request and op select (00 MULT, 01 MULTU, 10 DIV,
//                       11 DIVU); both are sampled only while idle
//   rs_val, rt_val      multiplicand/dividend, multiplier/divisor
//   busy, done          operation in progress / one-cycle completion pulse
//   hi, lo              product[63:32] / remainder, product[31:0] / quotient
//   alu_grant           sequencer drives the shared ALU operands (= busy)
//   alu_a, alu_b        ALU operands
//   alu_op              010 add, 110 subtract (A-B)
//   alu_r, alu_cout     ALU result and MSB carry-out, valid in the same cycle
// -----------------------------------------------------------------------------
module mdu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_grant,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r,
  input  logic             alu_cout
);

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE_A,
    S_PRE_B,
    S_ITER,
    S_POST_LO,
    S_POST_HI,
    S_FIN
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_div;     // 1: divide, 0: multiply
  logic             r_signed;  // MULT / DIV
  logic             r_sa;      // sign of rs for signed ops
  logic             r_sb;      // sign of rt for signed ops
  logic             r_z;       // low word was zero before negation
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_t;        // divide: partial remainder shifted left
  logic             w_m;        // divide: bit shifted out of hi (33rd bit)
  logic [WIDTH:0]   w_mul_sum;  // multiply: 33-bit add-or-pass of hi
  logic             w_neg;      // result sign differs from magnitude sign
  logic             w_last;

  assign w_t       = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_m       = r_hi[WIDTH-1];
  assign w_mul_sum = r_lo[0] ? {alu_cout, alu_r} : {1'b0, r_hi};
  assign w_neg     = r_sa ^ r_sb;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  assign busy      = r_busy;
  assign done      = r_done;
  assign alu_grant = r_busy;
  assign hi        = r_hi;
  assign lo        = r_lo;

  // ALU operand steering.
  // These outputs depend only on registered state, so there is no
  // combinational path from alu_r back into alu_a / alu_b.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_ADD;
    unique case (r_state)
      S_PRE_A: begin
        alu_op = OP_SUB;
        alu_b  = r_opa;
      end
      S_PRE_B: begin
        alu_op = OP_SUB;
        alu_b  = r_opb;
      end
      S_ITER: begin
        if (r_div) begin
          alu_op = OP_SUB;
          alu_a  = w_t;
          alu_b  = r_opb;
        end else if (r_lo[0]) begin
          alu_op = OP_ADD;
          alu_a  = r_hi;
          alu_b  = r_opa;
        end
      end
      S_POST_LO: begin
        alu_op = OP_SUB;
        alu_b  = r_lo;
      end
      S_POST_HI: begin
        if (r_div) begin
          alu_op = OP_SUB;
          alu_b  = r_hi;
        end else begin
          // Upper half of the 64-bit negation: ~hi plus the carry
          // out of the low word (set only when lo was zero).
          alu_op = OP_ADD;
          alu_a  = ~r_hi;
          alu_b  = {{(WIDTH-1){1'b0}}, r_z};
        end
      end
      default: begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = OP_ADD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_cnt    <= '0;
      r_opa    <= '0;
      r_opb    <= '0;
      r_div    <= 1'b0;
      r_signed <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_z      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa    <= rs_val;
            r_opb    <= rt_val;
            r_div    <= md_op[1];
            r_signed <= ~md_op[0];
            r_sa     <= ~md_op[0] & rs_val[WIDTH-1];
            r_sb     <= ~md_op[0] & rt_val[WIDTH-1];
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            if (md_op[1] && (rt_val == '0)) begin
              // Divide by zero: fixed result, no iterations.
              r_lo    <= '1;
              r_hi    <= rs_val;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_hi    <= '0;
              r_lo    <= md_op[1] ? rs_val : rt_val;
              r_state <= md_op[0] ? S_ITER : S_PRE_A;
            end
          end
        end

        S_PRE_A: begin
          if (r_opa[WIDTH-1]) r_opa <= alu_r;
          r_state <= S_PRE_B;
        end

        S_PRE_B: begin
          // Magnitudes are now final.
          // Seed {hi,lo} from the possibly negated operands.
          if (r_opb[WIDTH-1]) r_opb <= alu_r;
          r_hi  <= '0;
          if (r_div)
            r_lo <= r_opa;
          else
            r_lo <= r_opb[WIDTH-1] ? alu_r : r_opb;
          r_cnt   <= '0;
          r_state <= S_ITER;
        end

        S_ITER: begin
          if (r_div) begin
            if (w_m | alu_cout) begin
              r_hi <= alu_r;
              r_lo <= {r_lo[WIDTH-2:0], 1'b1};
            end else begin
              r_hi <= w_t;
              r_lo <= {r_lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            if (r_signed) begin
              r_state <= S_POST_LO;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end
          end
        end

        S_POST_LO: begin
          r_z <= (r_lo == '0);
          if (w_neg) r_lo <= alu_r;
          r_state <= S_POST_HI;
        end

        S_POST_HI: begin
          // Divide: the remainder follows the dividend's sign.
          // Multiply: finish the 64-bit negation.
          if (r_div ? r_sa : w_neg) r_hi <= alu_r;
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end

        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_grant;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_r;
  logic        alu_cout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .alu_grant (alu_grant),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_r     (alu_r),
    .alu_cout  (alu_cout)
  );

  // Shared ALU as seen by the sequencer: add, or A + ~B + 1 for subtract.
  logic [32:0] alu_ext;
  always_comb begin
    if (alu_op == 3'b110) alu_ext = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else                  alu_ext = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_r    = alu_ext[31:0];
  assign alu_cout = alu_ext[32];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] ehi,
                                output logic [31:0] elo, output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; ehi = p[63:32]; elo = p[31:0]; lat = 37; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; ehi = p[63:32]; elo = p[31:0]; lat = 33; end
      default: begin
        if (b == 32'd0) begin
          ehi = a; elo = 32'hFFFF_FFFF; lat = 1;
        end else if (op == 2'b11) begin
          elo = a / b; ehi = a % b; lat = 33;
        end else begin
          q = sa / sb; r = sa % sb;
          qv = q; rv = r;
          elo = qv[31:0]; ehi = rv[31:0]; lat = 37;
        end
      end
    endcase
  endfunction

  // Called just after a falling edge while idle; start is presented in
  // this cycle (cycle 0). Returns one falling edge after done, which is
  // the idle cycle where the next request may be issued.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int inject_at);
    logic [31:0] ehi, elo;
    int          elat, done_cyc, ctl_err;
    model(op, a, b, ehi, elo, elat);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    done_cyc = -1;
    ctl_err  = 0;
    for (int k = 1; k <= 120; k++) begin
      @(negedge clk);
      if (alu_grant !== 1'b1 || busy !== 1'b1) ctl_err++;
      if (alu_op !== 3'b010 && alu_op !== 3'b110) ctl_err++;
      if (done === 1'b1) begin
        done_cyc = k;
        break;
      end
      if (k == inject_at) begin
        start = 1'b1; md_op = 2'b11; rs_val = 32'd9; rt_val = 32'd3;
      end else begin
        start = 1'b0; md_op = 2'($urandom_range(0, 3));
        rs_val = $urandom; rt_val = $urandom;
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, 128'(done_cyc), 128'(elat));
    check({tag, ".hi"}, 128'(hi), 128'(ehi));
    check({tag, ".lo"}, 128'(lo), 128'(elo));
    check({tag, ".busy_grant"}, 128'(ctl_err), 128'(0));
    @(negedge clk);
    check({tag, ".idle_ctl"}, 128'({busy, done, alu_grant, alu_op, alu_a, alu_b}),
          128'({1'b0, 1'b0, 1'b0, 3'b010, 32'd0, 32'd0}));
    check({tag, ".hold"}, 128'({hi, lo}), 128'({ehi, elo}));
  endtask

  initial begin
    int          seen;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; md_op = 2'b00; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    check("reset", 128'({busy, done, alu_grant, hi, lo, alu_a, alu_b, alu_op}),
          128'({3'b000, 32'd0, 32'd0, 32'd0, 32'd0, 3'b010}));
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", 0);
    run_op(2'b00, -32'sd3, 32'd7, "mult_neg3x7", 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_minxmin", 0);
    run_op(2'b11, 32'd100, 32'd7, "divu_100_7", 0);
    run_op(2'b10, -32'sd7, 32'd2, "div_neg7_2", 0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, "divu_big", 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 0);
    run_op(2'b11, 32'd5, 32'd0, "divu_zero", 0);
    run_op(2'b10, 32'h1234_5678, 32'd0, "div_zero", 0);
    run_op(2'b01, 32'd6, 32'd7, "multu_ignore_start", 5);
    run_op(2'b11, 32'd9, 32'd3, "divu_b2b", 0);
    run_op(2'b00, 32'd0, 32'hFFFF_FFFF, "mult_zero_neg", 0);
    run_op(2'b10, 32'd7, -32'sd2, "div_7_neg2", 0);

    // Reset while iterating: abort, no done pulse, then a clean restart
    start = 1'b1; md_op = 2'b01; rs_val = 32'd1234; rt_val = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_abort", 128'({busy, done, alu_grant, hi, lo}), 128'({3'b000, 32'd0, 32'd0}));
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    check("rst_no_done", 128'(seen), 128'(0));
    run_op(2'b01, 32'd1234, 32'd5678, "after_reset", 0);

    // Randomised back-to-back operations
    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      run_op(rop, ra, rb, $sformatf("rand%0d", i), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for MULT, MULTU, DIV and DIVU.
- It does not contain its own adder. It borrows the shared 32-bit ALU (built from the 1-bit ALU slices) for every add, subtract and negate step.
- It holds the ALU while busy and returns results in HI/LO registers.
- It sits beside the execute stage. The core's ALU operand mux selects the sequencer's outputs whenever alu_grant=1.

Parameters:
- WIDTH, 32, operand/ALU width (only 32 supported).
- CNT_W, 6, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only when busy=0
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_val  in  32  multiplicand / dividend
- rt_val  in  32  multiplier / divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- hi  out  32  product[63:32] / remainder
- lo  out  32  product[31:0] / quotient
- alu_grant  out  1  sequencer owns the ALU (equals busy)
- alu_a  out  32  ALU operand A
- alu_b  out  32  ALU operand B
- alu_op  out  3  010 add, 110 subtract (A-B); other encodings never driven
- alu_r  in  32  ALU result, combinational, same cycle
- alu_cout  in  1  ALU MSB carry-out; for subtract, 1 means A>=B unsigned

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy, done, alu_grant=0; hi=lo=0; alu_a=alu_b=0; alu_op=010. Reset mid-operation aborts with no done pulse.
- When alu_grant=0, alu_a, alu_b and alu_op are don't-care and are driven 0/0/010.
- States: IDLE, PRE_A, PRE_B, ITER, POST_LO, POST_HI, FIN.
- IDLE, start=1:
  - Capture operands, op and sign flags.
  - Signed ops go to PRE_A. Unsigned ops go to ITER.
  - DIV/DIVU with rt_val=0 goes directly to FIN with lo=0xFFFFFFFF and hi=rs_val.
  - busy=1 from the next cycle.
- PRE_A: alu_op=110, A=0, B=opA. Replace opA with alu_r if opA[31]=1; otherwise hold.
- PRE_B: same for opB. Then go to ITER with counter=0.
- ITER, 32 cycles, counter 0..31; leave after counter=31.
  - Multiply:
    - Initial state: hi=0, lo=opB.
    - If lo[0]=1: alu_op=010, A=hi, B=opA, sum={alu_cout,alu_r}. Otherwise sum={0,hi}.
    - Update: {hi,lo} <= {sum,lo[31:1]}.
  - Divide:
    - Initial state: hi=0, lo=opA.
    - Set t={hi[30:0],lo[31]}, m=hi[31]. Drive alu_op=110, A=t, B=opB.
    - Accept if m|alu_cout: hi<=alu_r, lo<={lo[30:0],1}.
    - Otherwise: hi<=t, lo<={lo[30:0],0}.
  - Next state after ITER: signed -> POST_LO; unsigned -> FIN.
- POST_LO:
  - Register z=(lo==0).
  - MULT, signs differ: lo <= 0-lo via ALU.
  - DIV: lo is negated if sign(rs)^sign(rt).
- POST_HI:
  - MULT, signs differ: hi <= ~hi + z, using alu_op=010, A=~hi, B={31'b0,z}.
  - DIV: hi <= 0-hi if sign(rs)=1, giving a truncating quotient and a remainder with the dividend's sign.
- FIN: done=1 for exactly this cycle, busy=1. Next cycle goes to IDLE with busy=0.
- Latency from the start cycle (cycle 0) to done: unsigned 33; signed 37; divide-by-zero 1.
- hi/lo hold final values until the next accepted start. Intermediate values are visible while busy.
- start while busy=1 is ignored; operands are not re-sampled.
- start is accepted in the cycle after FIN (IDLE), so back-to-back operations are possible.
- Overflow case DIV 0x80000000/0xFFFFFFFF gives lo=0x80000000, hi=0; no trap.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; alu_grant=1 for cycles 1-33.
- MULT -3 x 7 -> done at cycle 37; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIVU 100/7 -> lo=14, hi=2 at cycle 33. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 37. DIVU 0xFFFFFFFF/0x80000001 -> lo=1, hi=0x7FFFFFFE.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 5/0 -> done at cycle 1, lo=0xFFFFFFFF, hi=5.
- MULTU 6x7 in progress; at cycle 5 assert start with DIVU 9/3 -> ignored; result hi=0, lo=42. In the cycle after FIN, issue DIVU 9/3 -> lo=3, hi=0 at +33.
- Start MULTU; drive rst_n=0 at ITER counter=10 -> next cycle busy=0, done=0, hi=lo=0, alu_grant=0. No done pulse follows. The next start runs normally.
